// File: rtl/quad_decoder_if.sv
// Encoder pin and decoder status bundle for quad_decoder.
// The slave modport is the decoder side; master is whoever drives the pins.
interface quad_decoder_if;
    logic       ena;
    logic       a_in;
    logic       b_in;
    logic       i_in;
    logic       err_clr;
    logic       step;
    logic       up;
    logic       idx;
    logic       err;
    logic       ready;
    logic [1:0] phase;

    modport master (
        output ena, a_in, b_in, i_in, err_clr,
        input  step, up, idx, err, ready, phase
    );

    modport slave (
        input  ena, a_in, b_in, i_in, err_clr,
        output step, up, idx, err, ready, phase
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature A/B/index decoder: synchronises and deglitches the encoder pins,
// emits one-cycle step/idx strobes with direction, and flags illegal A/B jumps.
module quad_decoder #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned MODE       = 4
) (
    input  logic          clk,
    input  logic          rst,
    quad_decoder_if.slave bus
);
    localparam int unsigned NPIN   = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned INIT_W = 9;
    localparam int unsigned PIN_A  = 2;
    localparam int unsigned PIN_B  = 1;
    localparam int unsigned PIN_I  = 0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [NPIN-1:0]   s1;
    logic [NPIN-1:0]   s2;
    logic [NPIN-1:0]   filt;
    logic [CNT_W-1:0]  cnt [NPIN];
    logic [INIT_W-1:0] init_cnt;
    logic              idx_prev;

    logic              step_q,  step_nxt;
    logic              up_q,    up_nxt;
    logic              idx_q,   idx_nxt;
    logic              err_q,   err_nxt;
    logic              ready_q, ready_nxt;
    logic [1:0]        phase_q, phase_nxt;

    logic              init_done_c;
    logic [1:0]        ab_c;
    logic [1:0]        pos_old_c;
    logic [1:0]        pos_new_c;
    logic [1:0]        delta_c;
    logic              legal_c;
    logic              counted_c;

    // Two-flop synchroniser, bit order {A, B, I}
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {bus.a_in, bus.b_in, bus.i_in};
            s2 <= s1;
        end
    end

    // INIT lasts FILTER_LEN+2 edges so s2 holds settled pin levels when loaded
    assign init_done_c = (state == ST_INIT) && (init_cnt == INIT_W'(FILTER_LEN + 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt <= '0;
        end else if ((state == ST_INIT) && !init_done_c) begin
            init_cnt <= init_cnt + INIT_W'(1);
        end
    end

    // Per-pin run-length filter: a new level must persist FILTER_LEN edges
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '0;
            for (int p = 0; p < NPIN; p++) cnt[p] <= '0;
        end else if (init_done_c) begin
            filt <= s2;
            for (int p = 0; p < NPIN; p++) cnt[p] <= '0;
        end else if (state == ST_RUN) begin
            for (int p = 0; p < NPIN; p++) begin
                if (s2[p] == filt[p]) begin
                    cnt[p] <= '0;
                end else if (cnt[p] == CNT_W'(FILTER_LEN - 1)) begin
                    filt[p] <= s2[p];
                    cnt[p]  <= '0;
                end else begin
                    cnt[p] <= cnt[p] + CNT_W'(1);
                end
            end
        end
    end

    // Preloaded at INIT exit so an index held high through reset gives no pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_prev <= 1'b0;
        end else if (init_done_c) begin
            idx_prev <= s2[PIN_I];
        end else begin
            idx_prev <= filt[PIN_I];
        end
    end

    // Map {A,B} onto a 0..3 cycle position so direction is a 2-bit difference
    always_comb begin
        ab_c      = filt[PIN_A:PIN_B];
        pos_old_c = {phase_q[0], phase_q[1] ^ phase_q[0]};
        pos_new_c = {ab_c[0], ab_c[1] ^ ab_c[0]};
        delta_c   = pos_new_c - pos_old_c;
        legal_c   = delta_c[0];
        if (MODE == 2) begin
            counted_c = ab_c[1] ^ phase_q[1];
        end else if (MODE == 1) begin
            counted_c = ((phase_q == 2'b00) && (ab_c == 2'b10)) ||
                        ((phase_q == 2'b10) && (ab_c == 2'b00));
        end else begin
            counted_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if ((state == ST_INIT) && init_done_c) begin
            state_nxt = ST_RUN;
        end
    end

    // Next values of the registered outputs; an illegal-event set beats err_clr
    always_comb begin
        step_nxt  = 1'b0;
        idx_nxt   = 1'b0;
        up_nxt    = up_q;
        err_nxt   = err_q;
        phase_nxt = phase_q;
        ready_nxt = ready_q;
        if (bus.err_clr) err_nxt = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_done_c) begin
                    phase_nxt = s2[PIN_A:PIN_B];
                    ready_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (ab_c != phase_q) begin
                    phase_nxt = ab_c;
                    if (!legal_c) begin
                        if (bus.ena) err_nxt = 1'b1;
                    end else if (bus.ena && counted_c) begin
                        step_nxt = 1'b1;
                        up_nxt   = (delta_c == 2'b01);
                    end
                end
                if (bus.ena && filt[PIN_I] && !idx_prev) idx_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q  <= 1'b0;
            up_q    <= 1'b1;
            idx_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            phase_q <= 2'b00;
        end else begin
            step_q  <= step_nxt;
            up_q    <= up_nxt;
            idx_q   <= idx_nxt;
            err_q   <= err_nxt;
            ready_q <= ready_nxt;
            phase_q <= phase_nxt;
        end
    end

    assign bus.step  = step_q;
    assign bus.up    = up_q;
    assign bus.idx   = idx_q;
    assign bus.err   = err_q;
    assign bus.ready = ready_q;
    assign bus.phase = phase_q;
endmodule
